// File: rtl/stream_mux_rr_if.sv
// Stream bus between N producers, the mux and one consumer.
// master = producer/consumer side, slave = mux side.
interface stream_mux_rr_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
);

  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH*WIDTH-1:0]   in_data;
  logic [NUM_CH-1:0]         in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer: manual select or round-robin arbitration,
// single registered output stage with full 1 beat/cycle throughput.
module stream_mux_rr #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stream_mux_rr_if.slave         sif
);

  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_load_en;
  logic              w_gnt_vld;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic [WIDTH-1:0]  w_gnt_data;
  logic [NUM_CH-1:0] w_in_ready;
  logic              w_xfer_in;
  logic [SEL_W-1:0]  w_ptr_nxt;
  int unsigned       w_rr_idx;

  // Output register may accept a new beat when empty or draining this cycle.
  assign w_load_en = !r_out_valid || sif.out_ready;
  assign w_xfer_in = rst_n && w_load_en && w_gnt_vld;

  // Grant selection: manual index, or first valid channel scanning from the rr pointer.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_rr_idx  = 0;
    if (!sif.mode) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if ((sif.sel == SEL_W'(i)) && sif.in_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        w_rr_idx = 32'(r_ptr) + k;
        if (w_rr_idx >= NUM_CH) begin
          w_rr_idx = w_rr_idx - NUM_CH;
        end
        if (!w_gnt_vld && sif.in_valid[w_rr_idx[SEL_W-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_rr_idx[SEL_W-1:0];
        end
      end
    end
  end

  // Data of the granted channel and per-channel ready (held low during reset).
  always_comb begin
    w_gnt_data = '0;
    w_in_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_gnt_idx == SEL_W'(i)) begin
        w_gnt_data = sif.in_data[i*WIDTH +: WIDTH];
      end
      w_in_ready[i] = w_xfer_in && (w_gnt_idx == SEL_W'(i));
    end
  end

  // Pointer moves past the winner, wrapping at NUM_CH rather than 2^SEL_W.
  assign w_ptr_nxt = (w_gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : (w_gnt_idx + SEL_W'(1));

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer_in) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_ch    <= w_gnt_idx;
        if (sif.mode) begin
          r_ptr <= w_ptr_nxt;
        end
      end else if (sif.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign sif.in_ready  = w_in_ready;
  assign sif.out_valid = r_out_valid;
  assign sif.out_data  = r_out_data;
  assign sif.out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr (NUM_CH=4, WIDTH=8): directed scenarios followed by
// random traffic, compared against a behavioural model of the handshake rules.
module tb_stream_mux_rr;

  localparam int unsigned NCH = 4;

  logic        clk;
  logic        rst_n;
  logic        t_mode;
  logic [1:0]  t_sel;
  logic [3:0]  t_valid;
  logic [7:0]  d [NCH];
  logic        t_oready;

  int n_checks;
  int n_errors;

  // Reference model state
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_ch;
  int          m_ptr;

  stream_mux_rr_if #(.NUM_CH(4), .WIDTH(8)) bus ();

  stream_mux_rr #(.NUM_CH(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus.slave)
  );

  assign bus.mode      = t_mode;
  assign bus.sel       = t_sel;
  assign bus.in_valid  = t_valid;
  assign bus.in_data   = {d[3], d[2], d[1], d[0]};
  assign bus.out_ready = t_oready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: check in_ready against the model, advance the model, check outputs.
  task automatic step(input string tag);
    int   g;
    bit   load;
    logic [3:0] exp_rdy;
    #1;
    g = -1;
    exp_rdy = 4'b0;
    if (rst_n) begin
      load = !m_valid || t_oready;
      if (!t_mode) begin
        if (t_valid[t_sel]) g = int'(t_sel);
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && t_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
      end
      if (load && g >= 0) exp_rdy = 4'(1 << g);
    end
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    if (!rst_n) begin
      m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 0;
    end else if (exp_rdy != 4'b0) begin
      m_valid = 1'b1; m_data = d[g]; m_ch = g;
      if (t_mode) m_ptr = (g + 1) % 4;
    end else if (t_oready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      check({tag, ".out_data"}, 32'(bus.out_data), 32'(m_data));
      check({tag, ".out_ch"},   32'(bus.out_ch),   32'(m_ch));
    end
  endtask

  initial begin
    int seq [6];
    int exp_ch;
    n_checks = 0; n_errors = 0;
    m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 0;
    seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0; seq[5] = 1;

    // Reset with every channel requesting
    rst_n = 1'b0; t_mode = 1'b1; t_sel = 2'd0; t_valid = 4'b1111; t_oready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 8'(8'h10 + i);
    step("rst0");
    step("rst1");
    check("rst.out_data", 32'(bus.out_data), 32'h0);
    check("rst.out_ch",   32'(bus.out_ch),   32'h0);

    // Manual select of channel 2
    rst_n = 1'b1; t_mode = 1'b0; t_sel = 2'd2; t_valid = 4'b0100; d[2] = 8'hA5;
    step("man_sel2");
    check("man.data_A5", 32'(bus.out_data), 32'hA5);
    t_sel = 2'd1;
    step("man_sel1_idle");
    check("man.drop", 32'(bus.out_valid), 32'h0);

    // Round-robin fairness with all channels valid
    t_mode = 1'b1; t_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 4; c++) d[c] = 8'($urandom);
      step("rr_fair");
      check("rr_fair.seq", 32'(bus.out_ch), 32'(seq[i]));
    end

    // Skip and wrap: pointer is 2 here; take channel 2 to reach ptr=3
    t_valid = 4'b0100; step("rr_to3");
    t_valid = 4'b0011; step("rr_skip0");
    check("rr_skip.ch0", 32'(bus.out_ch), 32'h0);
    step("rr_skip1");
    check("rr_skip.ch1", 32'(bus.out_ch), 32'h1);
    t_valid = 4'b1000; step("rr_wrap3");
    check("rr_wrap.ch3", 32'(bus.out_ch), 32'h3);
    t_valid = 4'b0001; step("rr_after_wrap");
    check("rr_wrap.ptr0", 32'(bus.out_ch), 32'h0);

    // Backpressure: hold for 3 cycles while inputs pend, then release
    t_valid = 4'b1111; t_oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) d[c] = 8'($urandom);
      step("bp_hold");
    end
    t_oready = 1'b1;
    #1;
    check("bp.release_ready", 32'(bus.in_ready != 4'b0), 32'h1);
    step("bp_release");

    // Mid-stream reset drops the held beat and clears the pointer
    t_oready = 1'b0; t_valid = 4'b1111;
    step("mid_load");
    rst_n = 1'b0;
    step("mid_rst");
    check("mid_rst.valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1; t_oready = 1'b1; t_valid = 4'b0110;
    exp_ch = 1;
    step("post_rst");
    check("post_rst.lowest", 32'(bus.out_ch), 32'(exp_ch));

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(99) != 0);
      if ($urandom_range(7) == 0) t_mode = 1'($urandom);
      t_sel    = 2'($urandom);
      t_valid  = 4'($urandom);
      t_oready = ($urandom_range(3) != 0);
      for (int c = 0; c < 4; c++) d[c] = 8'($urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
